// File: rtl/pid_pkg.sv
// Shared types and saturation helper for the PID error front end.
package pid_pkg;

  localparam int UW_DEFAULT = 8;
  localparam int IW_DEFAULT = 12;

  localparam int ERR_MAX   = (1 << UW_DEFAULT) - 1;
  localparam int ERR_MIN   = -ERR_MAX;
  localparam int DERIV_MAX = (1 << UW_DEFAULT) - 1;
  localparam int DERIV_MIN = -(1 << UW_DEFAULT);
  localparam int INTEG_MAX = (1 << (IW_DEFAULT - 1)) - 1;
  localparam int INTEG_MIN = -(1 << (IW_DEFAULT - 1));

  typedef enum logic {
    UNPRIMED = 1'b0,
    PRIMED   = 1'b1
  } primed_e;

  // Clamp a signed value into the two's-complement range of 'width' bits.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                    input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/pid_error_stage_if.sv
// Sample/result bundle between the distance sampler and the PID error stage.
interface pid_error_stage_if
  import pid_pkg::*;
#(
  parameter int UW = 8,
  parameter int IW = 12
);
  // Valid-only protocol: sample_valid_in qualifies sample_in/setpoint_in for
  // exactly one cycle and the stage always accepts it (no ready, no backpressure);
  // valid_out is a one-cycle pulse and the result outputs hold between pulses.
  logic                 sample_valid_in;
  logic [UW-1:0]        sample_in;
  logic [UW-1:0]        setpoint_in;
  logic                 clear_in;
  logic                 hold_in;
  logic                 valid_out;
  logic signed [UW:0]   err_out;
  logic signed [UW:0]   deriv_out;
  logic signed [IW-1:0] integ_out;
  primed_e              primed_state;

  modport master (
    output sample_valid_in, sample_in, setpoint_in, clear_in, hold_in,
    input  valid_out, err_out, deriv_out, integ_out, primed_state
  );

  modport slave (
    input  sample_valid_in, sample_in, setpoint_in, clear_in, hold_in,
    output valid_out, err_out, deriv_out, integ_out, primed_state
  );
endinterface

// File: rtl/saturating_adder_signed.sv
// Signed a+b with one guard bit, clamped to OUT_WIDTH two's-complement range.
module saturating_adder_signed
  import pid_pkg::*;
#(
  parameter int IN_WIDTH  = 13,
  parameter int OUT_WIDTH = 12
) (
  input  logic signed [IN_WIDTH-1:0]  a,
  input  logic signed [IN_WIDTH-1:0]  b,
  output logic signed [OUT_WIDTH-1:0] sum
);

  logic signed [IN_WIDTH:0] full;

  assign full = {a[IN_WIDTH-1], a} + {b[IN_WIDTH-1], b};
  assign sum  = OUT_WIDTH'(sat_signed(32'(full), OUT_WIDTH));

endmodule

// File: rtl/pid_error_stage.sv
// Two-stage PID front end: S1 forms the signed error, S2 forms the saturated
// D and I terms; a primed flag decides when a previous error exists.
module pid_error_stage
  import pid_pkg::*;
#(
  parameter int UNSIGNED_WIDTH = 8,
  parameter int INTEG_WIDTH    = 12
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  pid_error_stage_if.slave bus
);

  localparam int UW = UNSIGNED_WIDTH;
  localparam int IW = INTEG_WIDTH;

  logic [1:0]           rst_sync_q;
  logic                 rst_n;

  logic                 s1_valid_q;
  logic                 s1_first_q;
  logic signed [UW:0]   s1_err_q;

  logic signed [IW-1:0] integ_acc_q;
  logic signed [UW:0]   prev_q;
  primed_e              primed_q;
  primed_e              primed_d;

  logic                 cleared;
  logic signed [UW+1:0] d_a;
  logic signed [UW+1:0] d_b;
  logic signed [UW:0]   d_sum;
  logic signed [IW-1:0] i_a;
  logic signed [IW-1:0] i_b;
  logic signed [IW-1:0] i_sum;
  logic signed [UW:0]   deriv_next;
  logic signed [IW-1:0] integ_next;

  // Reset asserts immediately but is released on a clock edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_err_q   <= '0;
    end else begin
      s1_valid_q <= bus.sample_valid_in;
      if (bus.sample_valid_in) begin
        s1_err_q   <= $signed({1'b0, bus.sample_in}) - $signed({1'b0, bus.setpoint_in});
        s1_first_q <= bus.clear_in;
      end
    end
  end

  // A clear tagged on the sample or arriving now makes the S2 sample a fresh start.
  assign cleared = s1_first_q | bus.clear_in;

  assign d_a = (UW+2)'(s1_err_q);
  assign d_b = -((UW+2)'(prev_q));
  assign i_a = cleared ? '0 : integ_acc_q;
  assign i_b = IW'(s1_err_q);

  saturating_adder_signed #(.IN_WIDTH(UW+2), .OUT_WIDTH(UW+1)) u_deriv_add (
    .a   (d_a),
    .b   (d_b),
    .sum (d_sum)
  );

  saturating_adder_signed #(.IN_WIDTH(IW), .OUT_WIDTH(IW)) u_integ_add (
    .a   (i_a),
    .b   (i_b),
    .sum (i_sum)
  );

  always_comb begin
    deriv_next = d_sum;
    integ_next = i_sum;
    if (cleared || primed_q == UNPRIMED) deriv_next = '0;
    if (!cleared && bus.hold_in)          integ_next = integ_acc_q;
  end

  always_comb begin
    primed_d = primed_q;
    if (s1_valid_q)        primed_d = PRIMED;
    else if (bus.clear_in) primed_d = UNPRIMED;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) primed_q <= UNPRIMED;
    else        primed_q <= primed_d;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      bus.valid_out <= 1'b0;
      bus.err_out   <= '0;
      bus.deriv_out <= '0;
      bus.integ_out <= '0;
      integ_acc_q   <= '0;
      prev_q        <= '0;
    end else begin
      bus.valid_out <= s1_valid_q;
      if (s1_valid_q) begin
        bus.err_out   <= s1_err_q;
        bus.deriv_out <= deriv_next;
        bus.integ_out <= integ_next;
        integ_acc_q   <= integ_next;
        prev_q        <= s1_err_q;
      end else if (bus.clear_in) begin
        integ_acc_q <= '0;
        prev_q      <= '0;
      end
    end
  end

  assign bus.primed_state = primed_q;

endmodule
